// File: rtl/universal_shift_reg_p_if.sv
// Command/data bundle for universal_shift_reg_p: master is the issuing
// controller, slave is the shift register.
interface universal_shift_reg_p_if #(
   parameter int WIDTH = 8
);
   localparam int AMT_W = $clog2(WIDTH) + 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] inp;
   logic             serial_in;
   logic [WIDTH-1:0] out;
   logic             serial_out_l;
   logic             serial_out_r;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, mode, amount, inp, serial_in,
      input  cmd_ready, out, serial_out_l, serial_out_r, busy, done
   );

   modport slave (
      input  cmd_valid, mode, amount, inp, serial_in,
      output cmd_ready, out, serial_out_l, serial_out_r, busy, done
   );
endinterface

// File: rtl/universal_shift_reg_p.sv
// Multi-mode universal shift register executing one shift step per clock
// under a valid/ready command handshake, with a done pulse on completion.
//
// state | meaning
// IDLE  | ready for a command; immediate commands complete here
// SHIFT | multi-step shift running, one step per edge, cnt_q steps left
module universal_shift_reg_p #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   universal_shift_reg_p_if.slave  bus
);
   localparam int AMT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] MODE_NOP  = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [2:0]       mode_q, mode_d;
   logic             done_q, done_d;
   logic             accept;

   function automatic logic is_shift_mode(input logic [2:0] m);
      case (m)
         MODE_NOP, MODE_LOAD, MODE_CLR: is_shift_mode = 1'b0;
         default:                       is_shift_mode = 1'b1;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                   input logic [2:0]       m,
                                                   input logic             sin);
      case (m)
         MODE_SHL: shift_step = {v[WIDTH-2:0], sin};
         MODE_SHR: shift_step = {sin, v[WIDTH-1:1]};
         MODE_ROL: shift_step = {v[WIDTH-2:0], v[WIDTH-1]};
         MODE_ROR: shift_step = {v[0], v[WIDTH-1:1]};
         MODE_ASR: shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
         default:  shift_step = v;
      endcase
   endfunction

   assign accept = bus.cmd_valid && (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift_mode(bus.mode) && (bus.amount != '0)) begin
                  state_d = SHIFT;
                  mode_d  = bus.mode;
                  // Longer requests are clamped: more than WIDTH steps adds nothing useful.
                  cnt_d   = (bus.amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amount;
               end else begin
                  done_d = 1'b1;
                  case (bus.mode)
                     MODE_LOAD: out_d = bus.inp;
                     MODE_CLR:  out_d = '0;
                     default:   out_d = out_q;
                  endcase
               end
            end
         end
         SHIFT: begin
            out_d = shift_step(out_q, mode_q, bus.serial_in);
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         mode_q  <= MODE_NOP;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign bus.out          = out_q;
   assign bus.serial_out_l = out_q[WIDTH-1];
   assign bus.serial_out_r = out_q[0];
   assign bus.busy         = (state_q == SHIFT);
   assign bus.cmd_ready    = (state_q == IDLE);
   assign bus.done         = done_q;
endmodule

// File: tb/tb_universal_shift_reg_p.sv
// Directed bench for universal_shift_reg_p (WIDTH=8): a vector table of
// commands with hand-computed results plus handshake, reset and sampling sequences.
module tb_universal_shift_reg_p;
   localparam int WIDTH = 8;
   localparam int AMT_W = $clog2(WIDTH) + 1;

   typedef struct {
      logic [2:0]       mode;
      logic [AMT_W-1:0] amount;
      logic [7:0]       inp;
      logic             sin;
      logic [7:0]       exp_out;
      int               exp_steps;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   vec_t vecs[16];

   universal_shift_reg_p_if #(.WIDTH(WIDTH)) bus ();

   universal_shift_reg_p #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int steps;
      int busy_cnt;
      @(negedge clk);
      check($sformatf("v%0d ready", idx), 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.mode      = v.mode;
      bus.amount    = v.amount;
      bus.inp       = v.inp;
      bus.serial_in = v.sin;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.mode      = 3'b111;
      bus.inp       = 8'h5A;
      steps    = 0;
      busy_cnt = 0;
      while (!bus.done && steps < 40) begin
         if (bus.busy) busy_cnt++;
         @(posedge clk);
         #1;
         steps++;
      end
      check($sformatf("v%0d steps", idx), 32'(steps), 32'(v.exp_steps));
      check($sformatf("v%0d busy", idx), 32'(busy_cnt), 32'(v.exp_steps));
      check($sformatf("v%0d out", idx), 32'(bus.out), 32'(v.exp_out));
      check($sformatf("v%0d sl", idx), 32'(bus.serial_out_l), 32'(v.exp_out[7]));
      check($sformatf("v%0d sr", idx), 32'(bus.serial_out_r), 32'(v.exp_out[0]));
      @(posedge clk);
      #1;
      check($sformatf("v%0d done pulse", idx), 32'(bus.done), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      //          mode    amt    inp    sin   exp    steps
      vecs[0]  = '{3'b011, 4'd0,  8'hA5, 1'b0, 8'hA5, 0};
      vecs[1]  = '{3'b100, 4'd3,  8'h00, 1'b0, 8'h2D, 3};
      vecs[2]  = '{3'b011, 4'd0,  8'h90, 1'b0, 8'h90, 0};
      vecs[3]  = '{3'b110, 4'd2,  8'h00, 1'b0, 8'hE4, 2};
      vecs[4]  = '{3'b010, 4'd1,  8'h00, 1'b0, 8'h72, 1};
      vecs[5]  = '{3'b111, 4'd0,  8'hFF, 1'b1, 8'h00, 0};
      vecs[6]  = '{3'b001, 4'd12, 8'h00, 1'b1, 8'hFF, 8};
      vecs[7]  = '{3'b010, 4'd0,  8'h00, 1'b0, 8'hFF, 0};
      vecs[8]  = '{3'b000, 4'd5,  8'h00, 1'b0, 8'hFF, 0};
      vecs[9]  = '{3'b011, 4'd0,  8'h81, 1'b0, 8'h81, 0};
      vecs[10] = '{3'b101, 4'd4,  8'h00, 1'b0, 8'h18, 4};
      vecs[11] = '{3'b001, 4'd2,  8'h00, 1'b0, 8'h60, 2};
      vecs[12] = '{3'b010, 4'd3,  8'h00, 1'b1, 8'hEC, 3};
      vecs[13] = '{3'b110, 4'd3,  8'h00, 1'b1, 8'hFD, 3};
      vecs[14] = '{3'b100, 4'd15, 8'h00, 1'b0, 8'hFD, 8};
      vecs[15] = '{3'b111, 4'd0,  8'h00, 1'b0, 8'h00, 0};

      reset         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.mode      = 3'b000;
      bus.amount    = '0;
      bus.inp       = 8'h00;
      bus.serial_in = 1'b0;
      #12;
      check("rst out", 32'(bus.out), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst ready", 32'(bus.cmd_ready), 32'd1);
      check("rst done", 32'(bus.done), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Handshake: CLR held during a 4-step ROR, then accepted in the done cycle.
      run_vec(100, '{3'b011, 4'd0, 8'h81, 1'b0, 8'h81, 0});
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.mode      = 3'b101;
      bus.amount    = 4'd4;
      @(posedge clk);
      #1;
      bus.mode   = 3'b111;
      bus.amount = 4'd0;
      check("hs ready after accept", 32'(bus.cmd_ready), 32'd0);
      check("hs out E0", 32'(bus.out), 32'h81);
      @(posedge clk); #1;
      check("hs out E1", 32'(bus.out), 32'hC0);
      @(posedge clk); #1;
      check("hs out E2", 32'(bus.out), 32'h60);
      @(posedge clk); #1;
      check("hs out E3", 32'(bus.out), 32'h30);
      check("hs busy E3", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      check("hs out E4", 32'(bus.out), 32'h18);
      check("hs done E4", 32'(bus.done), 32'd1);
      check("hs ready E4", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("hs clr out", 32'(bus.out), 32'h00);
      check("hs clr done", 32'(bus.done), 32'd1);
      check("hs clr busy", 32'(bus.busy), 32'd0);

      // serial_in is not sampled on the accept edge.
      run_vec(101, '{3'b011, 4'd0, 8'h00, 1'b0, 8'h00, 0});
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.mode      = 3'b001;
      bus.amount    = 4'd1;
      bus.serial_in = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.serial_in = 1'b0;
      @(posedge clk); #1;
      check("sin accept out", 32'(bus.out), 32'h00);
      check("sin accept done", 32'(bus.done), 32'd1);

      // Asynchronous reset in the middle of a shift.
      run_vec(102, '{3'b011, 4'd0, 8'hA5, 1'b0, 8'hA5, 0});
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.mode      = 3'b001;
      bus.amount    = 4'd5;
      bus.serial_in = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("mid busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      check("arst out", 32'(bus.out), 32'd0);
      check("arst busy", 32'(bus.busy), 32'd0);
      check("arst ready", 32'(bus.cmd_ready), 32'd1);
      check("arst done", 32'(bus.done), 32'd0);
      check("arst sl", 32'(bus.serial_out_l), 32'd0);
      check("arst sr", 32'(bus.serial_out_r), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_vec(103, '{3'b011, 4'd0, 8'h3C, 1'b0, 8'h3C, 0});
      run_vec(104, '{3'b100, 4'd1, 8'h00, 1'b0, 8'h78, 1});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
